// File: rtl/ring_freq_meter_pkg.sv
// Shared types and helpers for the ring oscillator frequency meter.
// Used by ring_freq_meter (RING_FREQ_METER_GRAY_EN selects Gray readout there).
package ring_freq_meter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int unsigned SETTLE_CYCLES = 3;

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/ring_prescale.sv
// Per-channel divider clocked by a raw ring output; MSB is f_ring / 2^pDIV_LOG2.
// Cleared asynchronously with the system reset so all channels start from zero.
module ring_prescale #(
   parameter int pDIV_LOG2 = 3
) (
   input  logic ring_clk,
   input  logic rst_n,
   output logic msb
);

   logic [pDIV_LOG2-1:0] div_q;

   always_ff @(posedge ring_clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + pDIV_LOG2'(1);
      end
   end

   assign msb = div_q[pDIV_LOG2-1];

endmodule

// File: rtl/ring_freq_meter.sv
// Selects one prescaled ring, synchronises it and counts rises over a window of i_clk cycles.
// Build option RING_FREQ_METER_GRAY_EN presents o_count in Gray code.
//
// state   | meaning
// IDLE    | waiting for i_start; select and window latched on accept
// SETTLE  | synchroniser flush after the mux change, no counting
// MEASURE | count rises while the window down-counter runs to 1
// DONE    | publish count/overflow, pulse o_done, drop o_busy
module ring_freq_meter
   import ring_freq_meter_pkg::*;
#(
   parameter int pCHANNELS = 5,
   parameter int pDIV_LOG2 = 3,
   parameter int pCNT_W    = 16,
   parameter int pWIN_W    = 12
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [pCHANNELS-1:0]         i_ring,
   input  logic [$clog2(pCHANNELS)-1:0] i_sel,
   input  logic                         i_start,
   input  logic [pWIN_W-1:0]            i_win,
   output logic                         o_busy,
   output logic                         o_done,
   output logic [pCNT_W-1:0]            o_count,
   output logic                         o_overflow
);

   localparam int SEL_W    = $clog2(pCHANNELS);
   localparam int SETTLE_W = $clog2(SETTLE_CYCLES);
   localparam logic [pCNT_W-1:0] CNT_MAX = {pCNT_W{1'b1}};

   logic [pCHANNELS-1:0] msb;
   logic [SEL_W-1:0]     sel_q;
   logic [pWIN_W-1:0]    win_q;
   logic [pWIN_W-1:0]    win_cnt_q;
   logic [SETTLE_W-1:0]  settle_q;
   logic [pCNT_W-1:0]    count_q;
   logic                 ovf_q;
   logic                 mux_bit;
   logic                 sync1_q, sync2_q, hist_q;
   logic                 rise;
   logic                 accept;
   logic                 finish;
   state_t               state_q, state_d;

   for (genvar g = 0; g < pCHANNELS; g++) begin : g_pre
      ring_prescale #(.pDIV_LOG2(pDIV_LOG2)) u_pre (
         .ring_clk (i_ring[g]),
         .rst_n    (i_rst_n),
         .msb      (msb[g])
      );
   end

   // Out-of-range selects read as a constant low, which never produces a rise.
   always_comb begin
      mux_bit = 1'b0;
      if (int'(sel_q) < pCHANNELS) begin
         mux_bit = msb[sel_q];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= mux_bit;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign rise = sync2_q & ~hist_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = SETTLE;
               accept  = 1'b1;
            end
         end
         SETTLE: begin
            if (settle_q == '0) begin
               state_d = (win_q == '0) ? DONE : MEASURE;
            end
         end
         MEASURE: begin
            if (win_cnt_q == pWIN_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            finish  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sel_q      <= '0;
         win_q      <= '0;
         win_cnt_q  <= '0;
         settle_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_count    <= '0;
         o_overflow <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (accept) begin
            sel_q    <= i_sel;
            win_q    <= i_win;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            settle_q <= SETTLE_W'(SETTLE_CYCLES - 1);
            o_busy   <= 1'b1;
         end
         if (state_q == SETTLE) begin
            win_cnt_q <= win_q;
            if (settle_q != '0) begin
               settle_q <= settle_q - SETTLE_W'(1);
            end
         end
         if (state_q == MEASURE) begin
            win_cnt_q <= win_cnt_q - pWIN_W'(1);
            if (rise) begin
               if (count_q == CNT_MAX) begin
                  ovf_q <= 1'b1;
               end else begin
                  count_q <= count_q + pCNT_W'(1);
               end
            end
         end
         if (finish) begin
            o_done     <= 1'b1;
            o_busy     <= 1'b0;
            o_overflow <= ovf_q;
`ifdef RING_FREQ_METER_GRAY_EN
            o_count    <= pCNT_W'(bin2gray(32'(count_q)));
`else
            o_count    <= count_q;
`endif
         end
      end
   end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Scoreboard bench for ring_freq_meter: five rings of distinct periods, a default
// instance and a 4-bit-count instance for saturation; Gray-aware when the macro is set.
`timescale 1ns/1ps
module tb_ring_freq_meter;

   localparam int CH = 5;
   localparam int CW = 16;
   localparam int WW = 12;
   localparam int SW = 3;

   typedef struct {
      longint cnt;
      longint tol;
      logic   ovf;
      longint lat;
      longint t0;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic r0 = 1'b0, r1 = 1'b0, r2 = 1'b0, r3 = 1'b0, r4 = 1'b0;
   logic [CH-1:0] ring;
   logic [SW-1:0] sel = '0, sat_sel = '0;
   logic          start = 1'b0, sat_start = 1'b0;
   logic [WW-1:0] win = '0, sat_win = '0;
   logic          busy, done, ovf;
   logic [CW-1:0] count;
   logic          sat_busy, sat_done, sat_ovf;
   logic [3:0]    sat_count;

   int     per_ns[CH] = '{80, 60, 110, 200, 40};
   int     n_cmp = 0;
   int     n_bad = 0;
   longint cyc = 0;
   exp_t   q[$];
   exp_t   sq[$];

   always #5 clk = ~clk;
   always #40  r0 = ~r0;
   always #30  r1 = ~r1;
   always #55  r2 = ~r2;
   always #100 r3 = ~r3;
   always #20  r4 = ~r4;
   assign ring = {r4, r3, r2, r1, r0};

   always @(posedge clk) cyc <= cyc + 1;

   ring_freq_meter #(.pCHANNELS(CH), .pDIV_LOG2(3), .pCNT_W(CW), .pWIN_W(WW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ring(ring), .i_sel(sel), .i_start(start),
      .i_win(win), .o_busy(busy), .o_done(done), .o_count(count), .o_overflow(ovf)
   );

   ring_freq_meter #(.pCHANNELS(CH), .pDIV_LOG2(3), .pCNT_W(4), .pWIN_W(WW)) dut_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_ring(ring), .i_sel(sat_sel), .i_start(sat_start),
      .i_win(sat_win), .o_busy(sat_busy), .o_done(sat_done), .o_count(sat_count),
      .o_overflow(sat_ovf)
   );

   task automatic chk(input string tag, input longint obs, input longint exp, input longint tol = 0);
      n_cmp++;
      if (obs < exp - tol || obs > exp + tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
      end
   endtask

   function automatic longint to_bin(input longint v);
      longint b;
      b = v;
`ifdef RING_FREQ_METER_GRAY_EN
      for (int s = 1; s < 32; s = s * 2) b = b ^ (b >> s);
`endif
      return b;
   endfunction

   function automatic longint enc(input longint v);
`ifdef RING_FREQ_METER_GRAY_EN
      return v ^ (v >> 1);
`else
      return v;
`endif
   endfunction

   // Nearest whole number of prescaled periods that fit in the window (10 ns clock, /8).
   function automatic longint exp_cnt(input int ch, input int w);
      return (longint'(w) * 10 + per_ns[ch] * 4) / (per_ns[ch] * 8);
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("count", to_bin(count), e.cnt, e.tol);
            chk("overflow", ovf, e.ovf);
            chk("latency", cyc - e.t0, e.lat);
            chk("busy_at_done", busy, 0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && sat_done) begin
         if (sq.size() == 0) begin
            chk("sat_spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = sq.pop_front();
            chk("sat_count_raw", sat_count, e.cnt, e.tol);
            chk("sat_overflow", sat_ovf, e.ovf);
            chk("sat_latency", cyc - e.t0, e.lat);
         end
      end
   end

   task automatic measure(input int s, input int w, input longint ec, input longint tol,
                          input logic eo, input int poke);
      exp_t e;
      @(negedge clk);
      sel = SW'(s);
      win = WW'(w);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sel = SW'(0);
      win = WW'(7);
      e.cnt = ec; e.tol = tol; e.ovf = eo; e.lat = w + 4; e.t0 = cyc;
      q.push_back(e);
      chk("busy_set", busy, 1);
      for (int i = 0; i < w + 40 && q.size() != 0; i++) begin
         start = (i == poke);
         if (i == poke + 2 && poke < w) chk("busy_held", busy, 1);
         @(negedge clk);
      end
      start = 1'b0;
      if (q.size() != 0) begin
         chk("done_timeout", 0, 1);
         q.delete();
      end
      if (poke >= 0) begin
         repeat (20) @(negedge clk);
         chk("start_ignored", busy, 0);
      end
   endtask

   task automatic sat_measure(input int s, input int w, input longint ec, input logic eo);
      exp_t e;
      @(negedge clk);
      sat_sel = SW'(s);
      sat_win = WW'(w);
      sat_start = 1'b1;
      @(negedge clk);
      sat_start = 1'b0;
      e.cnt = ec; e.tol = 0; e.ovf = eo; e.lat = w + 4; e.t0 = cyc;
      sq.push_back(e);
      for (int i = 0; i < w + 40 && sq.size() != 0; i++) @(negedge clk);
      if (sq.size() != 0) begin
         chk("sat_done_timeout", 0, 1);
         sq.delete();
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_overflow", ovf, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      measure(0, 640, exp_cnt(0, 640), 1, 1'b0, -1);
      measure(3, 1000, exp_cnt(3, 1000), 1, 1'b0, -1);
      measure(7, 1000, 0, 0, 1'b0, -1);
      measure(1, 500, exp_cnt(1, 500), 1, 1'b0, -1);
      measure(0, 0, 0, 0, 1'b0, -1);
      measure(2, 300, exp_cnt(2, 300), 1, 1'b0, 50);
      measure(4, 200, exp_cnt(4, 200), 1, 1'b0, 203);

      sat_measure(4, 4000, enc(15), 1'b1);

      @(negedge clk);
      sel = SW'(0); win = WW'(1000); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_overflow", ovf, 0);
      chk("mid_rst_done", done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (1100) @(negedge clk);
      chk("post_rst_idle", busy, 0);

      measure(0, 640, exp_cnt(0, 640), 1, 1'b0, -1);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ring_freq_meter.md
Name: ring_freq_meter

Overview:
- Parametrised successor to the fixed-length ring oscillator bank.
- Accepts pCHANNELS free-running ring oscillator outputs and selects one.
- Prescales it in its own ring domain, synchronises it into i_clk, and counts prescaled edges over a programmable window of i_clk cycles.
- Returns a result count and an overflow flag, so ring frequency can be read on-chip instead of by probing raw pins.

Parameters:
- pCHANNELS, 5: number of ring inputs; 2..16.
- pDIV_LOG2, 3: prescaler divides the ring by 2^pDIV_LOG2; 1..8.
- pCNT_W, 16: result counter width.
- pWIN_W, 12: window-length field width.

Ports:
- i_clk  in  1  system clock; all control logic is on rising edge.
- i_rst_n  in  1  asynchronous active-low reset; also clears the prescalers.
- i_ring  in  pCHANNELS  raw ring oscillator outputs, asynchronous to i_clk.
- i_sel  in  $clog2(pCHANNELS)  channel select; sampled only at start.
- i_start  in  1  one-cycle pulse; begins a measurement when idle.
- i_win  in  pWIN_W  window length in i_clk cycles; sampled at start.
- o_busy  out  1  high from the accepted start until o_done.
- o_done  out  1  one-cycle pulse when o_count is valid.
- o_count  out  pCNT_W  prescaled edge count; holds until the next o_done.
- o_overflow  out  1  counter saturated during the last window; holds with o_count.

Behaviour:
- Clock and reset:
  - One clock, i_clk. Reset i_rst_n is asynchronous and active-low.
  - On reset, all outputs are 0, the FSM is IDLE, and every prescaler is 0.
- Prescaler:
  - Each channel has a pDIV_LOG2-bit ripple counter clocked by i_ring[n] and asynchronously cleared by i_rst_n.
  - Tap the MSB, giving a square wave at f_ring/2^pDIV_LOG2.
- Sync and select:
  - Mux the selected MSB using a registered select (sel_q).
  - The mux output passes through a 2-flop synchroniser plus one history flop.
  - A rise is defined as sync=1 and history=0.
- FSM states:
  - IDLE: i_start=1 → latch sel_q=i_sel and win_q=i_win, clear the count, set o_busy, go to SETTLE.
  - SETTLE: 3 cycles so the synchroniser flushes after the mux change; no counting. Then go to MEASURE with the window counter = win_q.
  - MEASURE: each cycle, a rise increments the count. The window counter decrements; on the cycle it reaches 1, go to DONE. Exactly win_q cycles are sampled.
  - DONE: one cycle. Load o_count and o_overflow, pulse o_done, clear o_busy, go to IDLE.
- Window boundary:
  - i_win=0 skips MEASURE: SETTLE goes straight to DONE with count 0 and overflow 0.
- Start handling:
  - i_start while o_busy is ignored; no queueing.
  - i_start in the DONE cycle is ignored.
- Count width rules:
  - The count saturates at 2^pCNT_W-1. Any further rise sets the overflow flag instead of wrapping.
- Accuracy:
  - Rises faster than f_clk/2 after prescaling alias. This is documented; no detection is required.
- Latency: from the i_start cycle to o_done = 3 + win_q + 1 cycles (win_q≥1).
- Reset mid-measurement: returns to IDLE immediately with o_busy=0 and outputs cleared. No o_done is issued.
- Out-of-range select: i_sel ≥ pCHANNELS selects constant 0, so the count result is 0.

Optional Feature:
- Macro: RING_FREQ_METER_GRAY_EN.
- Defined: o_count is presented in Gray code (bin ^ (bin>>1)), registered at DONE. Saturation is applied before encoding. This is for the board readout path and makes single-bit-change sampling safe.
- Undefined: o_count is plain binary.
- Timing, o_overflow and o_done are identical in both builds.

Decomposition:
- Package ring_freq_meter_pkg holds:
  - the FSM state enum (IDLE, SETTLE, MEASURE, DONE);
  - the constant SETTLE_CYCLES=3;
  - a function bin2gray.
- One sub-module, ring_prescale: a per-channel async-clocked divider with async clear, instantiated pCHANNELS times via generate.
- Sync, mux, FSM and counter stay in the top.

Test Plan:
- Single channel, in-window count: ring0 as an ideal 8x-clk-period square (prescaled period 64 clk), i_win=640 → o_count=10±1, o_overflow=0, o_done at start+644.
- Channel select: five rings at distinct periods, i_sel=3, i_win=1000 → count matches ring3 only; i_sel=7 → 0.
- Saturation and Gray: pCNT_W=4, fast ring, i_win=4000 → o_count=15, o_overflow=1. With RING_FREQ_METER_GRAY_EN, o_count=4'b1000.
- Boundaries: i_win=0 → o_done at start+4, count 0. i_start pulsed while busy → ignored, single o_done.
- Mid-measurement reset: assert i_rst_n=0 mid-MEASURE → o_busy=0 and o_count=0 asynchronously. No o_done. A new start afterward measures normally.
